// File: rtl/pcie_sym_pkg.sv
// pcie_sym_pkg: K28.5 comma constants and alignment state type.
package pcie_sym_pkg;
    localparam logic [9:0] K28P5_RDN = 10'h17C;
    localparam logic [9:0] K28P5_RDP = 10'h283;
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} align_state_t;
endpackage

// File: rtl/pcie_comma_det.sv
// pcie_comma_det: combinational K28.5 match of either running disparity.
module pcie_comma_det
    import pcie_sym_pkg::*;
(
    input  logic [9:0] win,
    output logic       hit
);
    assign hit = (win == K28P5_RDN) || (win == K28P5_RDP);
endmodule

// File: rtl/sipo_comma_align.sv
// sipo_comma_align: serial-to-10b deserializer with K28.5 alignment FSM.
// Define SIPO_ALIGN_ERR_CNT_EN to add the saturating err_cnt output.
module sipo_comma_align
    import pcie_sym_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sin,
    output logic [9:0] sym,
    output logic       sym_valid,
    output logic       comma_det,
    output logic       locked
`ifdef SIPO_ALIGN_ERR_CNT_EN
    ,output logic [7:0] err_cnt
`endif
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    logic [9:0] window, nwin;
    logic [3:0] bit_cnt;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    align_state_t state;
    logic hit, bnd;
    assign nwin = {sin, window[9:1]};
    assign bnd = (state != HUNT) && (bit_cnt == 4'd9);
    pcie_comma_det u_det (.win(nwin), .hit(hit));
    always_ff @(posedge clk) begin
        if (rst) begin
            window <= '0;
            sym <= '0;
            bit_cnt <= '0;
            good_cnt <= '0;
            bad_cnt <= '0;
            sym_valid <= 1'b0;
            comma_det <= 1'b0;
            locked <= 1'b0;
            state <= HUNT;
`ifdef SIPO_ALIGN_ERR_CNT_EN
            err_cnt <= '0;
`endif
        end else begin
            sym_valid <= 1'b0;
            comma_det <= 1'b0;
            if (en) begin
                window <= nwin;
                comma_det <= hit;
                bit_cnt <= (bnd || state == HUNT) ? 4'd0 : bit_cnt + 4'd1;
                if (bnd) begin
                    sym <= nwin;
                    sym_valid <= 1'b1;
                end
                case (state)
                    HUNT: if (hit) begin
                        sym <= nwin;
                        sym_valid <= 1'b1;
                        good_cnt <= GW'(1);
                        state <= SYNC;
                    end
                    SYNC: if (hit && bnd) begin
                        if (good_cnt + GW'(1) == GW'(LOCK_CNT)) begin
                            state <= LOCKED;
                            locked <= 1'b1;
                            good_cnt <= '0;
`ifdef SIPO_ALIGN_ERR_CNT_EN
                            err_cnt <= '0;
`endif
                        end else good_cnt <= good_cnt + GW'(1);
                    end else if (hit) begin
                        // misaligned comma in SYNC: restart symbol timing on it
                        sym <= nwin;
                        sym_valid <= 1'b1;
                        bit_cnt <= 4'd0;
                        good_cnt <= GW'(1);
                    end
                    LOCKED: if (hit && bnd) bad_cnt <= '0;
                    else if (hit) begin
`ifdef SIPO_ALIGN_ERR_CNT_EN
                        err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
`endif
                        if (bad_cnt + BW'(1) == BW'(LOSS_CNT)) begin
                            state <= HUNT;
                            locked <= 1'b0;
                            bad_cnt <= '0;
                        end else bad_cnt <= bad_cnt + BW'(1);
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: doc/sipo_comma_align.md
SIPO_COMMA_ALIGN -- requirements
Module: sipo_comma_align

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 3: the number of consecutive aligned commas needed to reach LOCKED.
REQ-002 The block SHALL have parameter LOSS_CNT, default 4: the number of misaligned commas in LOCKED that force a return to HUNT.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port en SHALL be an input, 1 bit: bit-valid strobe; sin is sampled only when en=1.
REQ-006 Port sin SHALL be an input, 1 bit: serial data, LSB (8b/10b bit a) first.
REQ-007 Port sym SHALL be an output, 10 bits: the aligned 10-bit symbol; bit0 is the first bit received.
REQ-008 Port sym_valid SHALL be an output, 1 bit: a one-cycle pulse when sym is updated.
REQ-009 Port comma_det SHALL be an output, 1 bit: a one-cycle pulse when the shift window matches K28.5 at any bit position.
REQ-010 Port locked SHALL be an output, 1 bit: high when and only when the state is LOCKED.

Function
REQ-011 On each edge with en=1, window SHALL load {sin, window[9:1]}; with en=0, all state SHALL hold and sym_valid and comma_det SHALL be 0.
REQ-012 Comma match SHALL compare the next window value against 10'h17C (K28.5 RD-) or 10'h283 (RD+).
REQ-013 The states SHALL be HUNT, SYNC and LOCKED; bit_cnt SHALL be 4 bits, count 0..9, and wrap 9->0 at each symbol boundary.
REQ-014 In HUNT, a comma match SHALL set sym to the new window, pulse sym_valid, clear bit_cnt, set good_cnt to 1 and move to SYNC; any other en cycle SHALL emit no symbol.
REQ-015 In SYNC or LOCKED, an en edge with bit_cnt=9 SHALL be a boundary: sym takes the new window, sym_valid pulses, and bit_cnt goes to 0.
REQ-016 In SYNC, an aligned comma SHALL increment good_cnt, and when good_cnt reaches LOCK_CNT the state SHALL move to LOCKED with good_cnt cleared.
REQ-017 In SYNC, a misaligned comma SHALL realign immediately: sym_valid pulses with the comma, bit_cnt clears and good_cnt is set to 1.
REQ-018 In LOCKED, a misaligned comma SHALL increment bad_cnt without realigning or emitting a symbol, and an aligned comma SHALL clear bad_cnt.
REQ-019 In LOCKED, when bad_cnt reaches LOSS_CNT, the state SHALL move to HUNT on that same edge with bad_cnt cleared.
REQ-020 Non-comma boundaries SHALL NOT change good_cnt or bad_cnt.
REQ-021 All outputs SHALL be registered, with a latency of 0 cycles from the edge that samples the tenth bit to sym_valid being high.

Reset
REQ-022 When rst=1 at a clock edge, window, sym, bit_cnt, good_cnt and bad_cnt SHALL be set to 0, sym_valid, comma_det and locked SHALL be 0, and the state SHALL be HUNT.
REQ-023 rst SHALL take priority over en, including when asserted mid-symbol or while in LOCKED; the first en edge after reset releases SHALL shift normally.

Configuration
REQ-024 Defining SIPO_ALIGN_ERR_CNT_EN SHALL add output err_cnt, 8 bits, which counts misaligned commas seen in LOCKED, saturates at 255, clears on reset, and clears on entry to LOCKED.
REQ-025 Without SIPO_ALIGN_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package pcie_sym_pkg SHALL hold the K28P5_RDN (10'h17C) and K28P5_RDP (10'h283) constants and the align_state_t enum (HUNT, SYNC, LOCKED).
REQ-027 Comma matching SHALL be in sub-module pcie_comma_det, a combinational 10-bit match instanced once.

Verification
REQ-028 Reset: hold rst=1 with en=1 and random sin for 5 cycles -> sym=0, sym_valid=0, locked=0.
REQ-029 Acquire: 3 random bits, then K28.5 RD- followed by D-symbols and commas every 4th symbol -> first sym_valid with sym=10'h17C; locked rises on the third aligned comma.
REQ-030 Gapped enable: the same stream with en=0 on alternate cycles -> identical sym sequence, with sym_valid only on en edges.
REQ-031 Slip: when LOCKED, drop one bit, then send commas -> bad_cnt increments; after 4 misaligned commas the block returns to HUNT and realigns on the next comma.
REQ-032 Mid-lock reset: assert rst for 1 cycle mid-symbol while LOCKED -> locked=0 next cycle, and reacquisition needs 3 aligned commas.
REQ-033 Macro: with SIPO_ALIGN_ERR_CNT_EN defined, inject 300 misaligned commas with LOSS_CNT=1000 -> err_cnt saturates at 255.
